// File: rtl/renode_pkg.sv
// rtl/renode_pkg.sv - shared AXI response codes and request/response types for the Renode bus manager
package renode_pkg;

  localparam int MaxAddressWidth = 64;
  localparam int MaxDataWidth    = 64;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef struct packed {
    logic                         write;
    logic [MaxAddressWidth-1:0]   address;
    logic [MaxDataWidth-1:0]      data;
    logic [MaxDataWidth/8-1:0]    strobe;
  } bus_request_t;

  typedef struct packed {
    logic [MaxDataWidth-1:0] data;
    logic                    error;
    logic                    timeout;
  } bus_response_t;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return axi_resp_e'(resp) inside {SLVERR, DECERR};
  endfunction

endpackage

// File: rtl/renode_timeout_counter.sv
// rtl/renode_timeout_counter.sv - saturating per-transaction cycle budget; TimeoutCycles=0 disables expiry
module renode_timeout_counter #(
  parameter int TimeoutCycles = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CountWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CountWidth-1:0] Last = CountWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  logic [CountWidth-1:0] count;

  // The accept cycle is the first budgeted cycle, so a restart loads one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= CountWidth'(1);
    end else if (enable && (count < Last)) begin
      count <= count + CountWidth'(1);
    end
  end

  assign expired = (TimeoutCycles > 0) && (count >= Last);

endmodule

// File: rtl/renode_axi_lite_manager.sv
// rtl/renode_axi_lite_manager.sv - executes single Renode bridge requests as AXI4-Lite manager transactions
module renode_axi_lite_manager
  import renode_pkg::*;
#(
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [AddressWidth-1:0] req_address,
  input  logic [DataWidth-1:0]    req_data,
  input  logic [DataWidth/8-1:0]  req_strobe,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataWidth-1:0]    rsp_data,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [AddressWidth-1:0] awaddr,
  output logic [2:0]              awprot,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DataWidth-1:0]    wdata,
  output logic [DataWidth/8-1:0]  wstrb,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [AddressWidth-1:0] araddr,
  output logic [2:0]              arprot,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DataWidth-1:0]    rdata,
  input  logic [1:0]              rresp
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESPOND} state_e;

  state_e                  state_q, state_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [AddressWidth-1:0] addr_q;
  logic [DataWidth-1:0]    data_q;
  logic [DataWidth/8-1:0]  strb_q;
  logic [DataWidth-1:0]    rsp_data_q, rsp_data_d;
  logic                    rsp_error_q, rsp_error_d, rsp_timeout_q, rsp_timeout_d;
  logic                    accept, expired, counting;

  assign accept   = req_valid && (state_q == IDLE);
  assign counting = state_q inside {WR, WR_RESP, RD_ADDR, RD_DATA};

  renode_timeout_counter #(.TimeoutCycles(TimeoutCycles)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (counting),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      strb_q        <= '0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      if (accept) begin
        addr_q <= req_address;
        data_q <= req_data;
        strb_q <= req_strobe;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d       = req_write ? WR : RD_ADDR;
          aw_done_d     = 1'b0;
          w_done_d      = 1'b0;
          rsp_data_d    = '0;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end
      WR: begin
        aw_done_d = aw_done_q || awready;
        w_done_d  = w_done_q || wready;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end else if (expired) begin
          state_d = RESPOND;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_d     = RESPOND;
          rsp_error_d = resp_is_error(bresp);
        end else if (expired) begin
          state_d = RESPOND;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          state_d = RD_DATA;
        end else if (expired) begin
          state_d = RESPOND;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          state_d     = RESPOND;
          rsp_error_d = resp_is_error(rresp);
          rsp_data_d  = resp_is_error(rresp) ? '0 : rdata;
        end else if (expired) begin
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Expiry without a completing handshake aborts the transaction.
    if (counting && (state_d == RESPOND) && !(bvalid && state_q == WR_RESP) &&
        !(rvalid && state_q == RD_DATA)) begin
      rsp_error_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_data_d    = '0;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign awvalid     = (state_q == WR) && !aw_done_q;
  assign wvalid      = (state_q == WR) && !w_done_q;
  assign arvalid     = (state_q == RD_ADDR);
  assign bready      = (state_q == WR_RESP) || (state_q == IDLE);
  assign rready      = (state_q == RD_DATA) || (state_q == IDLE);
  assign awaddr      = addr_q;
  assign araddr      = addr_q;
  assign wdata       = data_q;
  assign wstrb       = strb_q;
  assign awprot      = 3'b000;
  assign arprot      = 3'b000;
  assign rsp_valid   = (state_q == RESPOND);
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_renode_axi_lite_manager.sv
// tb/tb_renode_axi_lite_manager.sv - directed self-checking bench for renode_axi_lite_manager
module tb_renode_axi_lite_manager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_address, req_data;
  logic [3:0]  req_strobe;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [31:0] rsp_data;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int errors = 0;
  int checks = 0;

  int          rsp_k, ack_k, aw_beats, w_beats, ar_beats;
  logic [31:0] got_awaddr, got_wdata, got_araddr, got_data;
  logic [3:0]  got_wstrb;
  logic        got_error, got_timeout, rdy_in_rsp, stable_ok;
  logic [2:0]  valids_in_rsp;

  always #5 clk = ~clk;

  renode_axi_lite_manager #(.AddressWidth(32), .DataWidth(32), .TimeoutCycles(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data), .req_strobe(req_strobe),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  task automatic clear_inputs();
    req_valid = 0; req_write = 0; req_address = '0; req_data = '0; req_strobe = '0;
    rsp_ready = 0; awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = '0; rvalid = 0; rresp = '0; rdata = '0;
  endtask

  // Ready inputs stay high from their start cycle so a repeated valid shows up as an extra beat.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_at, input int w_at, input int b_at,
                         input int ar_at, input int r_at, input logic [1:0] resp,
                         input logic [31:0] rd, input int hold);
    int k;
    bit b_seen, r_seen, done;
    rsp_k = -1; ack_k = -1; aw_beats = 0; w_beats = 0; ar_beats = 0;
    got_awaddr = '0; got_wdata = '0; got_araddr = '0; got_wstrb = '0; got_data = '0;
    got_error = 0; got_timeout = 0; rdy_in_rsp = 0; stable_ok = 1; valids_in_rsp = '0;
    b_seen = 0; r_seen = 0; done = 0;
    req_valid = 1; req_write = wr; req_address = addr; req_data = data; req_strobe = strb;
    @(posedge clk); #1;
    req_valid = 0; req_write = 0; req_address = '0; req_data = '0; req_strobe = '0;
    k = 1;
    while (!done && k < 1000) begin
      awready = (aw_at >= 0) && (k >= aw_at);
      wready  = (w_at >= 0) && (k >= w_at);
      arready = (ar_at >= 0) && (k >= ar_at);
      bvalid  = (b_at >= 0) && (k >= b_at) && !b_seen;
      bresp   = bvalid ? resp : 2'b00;
      rvalid  = (r_at >= 0) && (k >= r_at) && !r_seen;
      rresp   = rvalid ? resp : 2'b00;
      rdata   = rvalid ? rd : 32'h0;
      rsp_ready = (hold == 0) || ((rsp_k >= 0) && (k >= rsp_k + hold));
      @(negedge clk);
      if (awvalid && awready) begin aw_beats++; got_awaddr = awaddr; end
      if (wvalid && wready) begin w_beats++; got_wdata = wdata; got_wstrb = wstrb; end
      if (arvalid && arready) begin ar_beats++; got_araddr = araddr; end
      if (bvalid && bready) b_seen = 1;
      if (rvalid && rready) r_seen = 1;
      if (rsp_valid) begin
        if (rsp_k < 0) begin
          rsp_k = k; got_data = rsp_data; got_error = rsp_error; got_timeout = rsp_timeout;
          rdy_in_rsp = req_ready; valids_in_rsp = {awvalid, wvalid, arvalid};
        end else if (rsp_data !== got_data || rsp_error !== got_error || rsp_timeout !== got_timeout) begin
          stable_ok = 0;
        end
        if (rsp_ready) begin done = 1; ack_k = k; end
      end
      @(posedge clk); #1;
      k++;
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if ({awvalid, wvalid, arvalid, rsp_valid} !== 4'b0) begin errors++; $display("FAIL reset_valids got %b want 0000", {awvalid, wvalid, arvalid, rsp_valid}); end
    checks++; if ({bready, rready} !== 2'b11) begin errors++; $display("FAIL reset_readies got %b want 11", {bready, rready}); end
    checks++; if ({rsp_data, rsp_error, rsp_timeout, awaddr, wdata} !== '0) begin errors++; $display("FAIL reset_regs rsp_data=%h awaddr=%h wdata=%h want 0", rsp_data, awaddr, wdata); end
  endtask

  task automatic test_write_zero_wait();
    run_txn(1, 32'h1000, 32'hDEADBEEF, 4'hF, 1, 1, 2, -1, -1, 2'b00, 32'h0, 0);
    checks++; if (rsp_k !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", rsp_k); end
    checks++; if (got_awaddr !== 32'h1000) begin errors++; $display("FAIL wr_awaddr got %h want 00001000", got_awaddr); end
    checks++; if ({got_wdata, got_wstrb} !== {32'hDEADBEEF, 4'hF}) begin errors++; $display("FAIL wr_wdata got %h/%h want deadbeef/f", got_wdata, got_wstrb); end
    checks++; if ({got_error, got_timeout, got_data} !== 34'h0) begin errors++; $display("FAIL wr_rsp err=%b to=%b data=%h want 0", got_error, got_timeout, got_data); end
    checks++; if (rdy_in_rsp !== 1'b0) begin errors++; $display("FAIL wr_req_ready_in_respond got %b want 0", rdy_in_rsp); end
    checks++; if ({awprot, arprot} !== 6'b0) begin errors++; $display("FAIL prot got %b want 0", {awprot, arprot}); end
  endtask

  task automatic test_read_wait();
    run_txn(0, 32'h2004, 32'h0, 4'h0, -1, -1, -1, 1, 7, 2'b00, 32'h12345678, 0);
    checks++; if (rsp_k !== 8) begin errors++; $display("FAIL rd_latency got %0d want 8", rsp_k); end
    checks++; if (got_araddr !== 32'h2004 || ar_beats !== 1) begin errors++; $display("FAIL rd_araddr got %h beats %0d want 00002004/1", got_araddr, ar_beats); end
    checks++; if ({got_data, got_error, got_timeout} !== {32'h12345678, 2'b00}) begin errors++; $display("FAIL rd_rsp data=%h err=%b to=%b want 12345678/0/0", got_data, got_error, got_timeout); end
  endtask

  task automatic test_write_order();
    int aw_tab[3] = '{5, 1, 3};
    int w_tab[3]  = '{1, 5, 3};
    for (int i = 0; i < 3; i++) begin
      run_txn(1, 32'h3000 + i, 32'hA5A50000 + i, 4'h3, aw_tab[i], w_tab[i], 6, -1, -1, 2'b01, 32'h0, 0);
      checks++; if (aw_beats !== 1 || w_beats !== 1) begin errors++; $display("FAIL wr_order%0d beats aw=%0d w=%0d want 1/1", i, aw_beats, w_beats); end
      checks++; if (rsp_k !== 7 || got_error !== 1'b0) begin errors++; $display("FAIL wr_order%0d rsp_k=%0d err=%b want 7/0", i, rsp_k, got_error); end
    end
  endtask

  task automatic test_errors();
    run_txn(0, 32'h4000, 32'h0, 4'h0, -1, -1, -1, 1, 2, 2'b10, 32'hFFFFFFFF, 0);
    checks++; if ({rsp_k == 3, got_error, got_timeout, got_data} !== {3'b110, 32'h0}) begin errors++; $display("FAIL rd_slverr k=%0d err=%b to=%b data=%h want 3/1/0/0", rsp_k, got_error, got_timeout, got_data); end
    run_txn(1, 32'h4004, 32'h11112222, 4'h1, 1, 1, 2, -1, -1, 2'b11, 32'h0, 0);
    checks++; if ({got_error, got_timeout, got_data} !== {2'b10, 32'h0}) begin errors++; $display("FAIL wr_decerr err=%b to=%b data=%h want 1/0/0", got_error, got_timeout, got_data); end
    run_txn(0, 32'h4008, 32'h0, 4'h0, -1, -1, -1, 1, 2, 2'b01, 32'hCAFEF00D, 0);
    checks++; if ({got_error, got_data} !== {1'b0, 32'hCAFEF00D}) begin errors++; $display("FAIL rd_exokay err=%b data=%h want 0/cafef00d", got_error, got_data); end
  endtask

  task automatic test_timeout();
    run_txn(0, 32'h5000, 32'h0, 4'h0, -1, -1, -1, -1, -1, 2'b00, 32'h0, 0);
    checks++; if (rsp_k !== 100) begin errors++; $display("FAIL rd_timeout_latency got %0d want 100", rsp_k); end
    checks++; if ({got_error, got_timeout, got_data, valids_in_rsp} !== {2'b11, 32'h0, 3'b000}) begin errors++; $display("FAIL rd_timeout_rsp err=%b to=%b data=%h valids=%b want 1/1/0/000", got_error, got_timeout, got_data, valids_in_rsp); end
    run_txn(0, 32'h5004, 32'h0, 4'h0, -1, -1, -1, 99, 100, 2'b00, 32'h0BADBEEF, 0);
    checks++; if ({rsp_k == 101, got_error, got_timeout, got_data} !== {3'b100, 32'h0BADBEEF}) begin errors++; $display("FAIL rd_expiry_race k=%0d err=%b to=%b data=%h want 101/0/0/0badbeef", rsp_k, got_error, got_timeout, got_data); end
    run_txn(1, 32'h5008, 32'h1, 4'hF, 1, 1, -1, -1, -1, 2'b00, 32'h0, 0);
    checks++; if ({rsp_k == 100, got_error, got_timeout} !== 3'b111) begin errors++; $display("FAIL wr_timeout k=%0d err=%b to=%b want 100/1/1", rsp_k, got_error, got_timeout); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1; req_write = 1; req_address = 32'h6000; req_data = 32'h66; req_strobe = 4'hF;
    @(posedge clk); #1;
    clear_inputs();
    awready = 1; wready = 1;
    @(posedge clk); #1;
    awready = 0; wready = 0;
    @(negedge clk);
    checks++; if ({bready, awvalid, wvalid} !== 3'b100) begin errors++; $display("FAIL mid_in_wr_resp got %b want 100", {bready, awvalid, wvalid}); end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    checks++; if ({awvalid, wvalid, arvalid, rsp_valid, req_ready} !== 5'b00001) begin errors++; $display("FAIL mid_reset got %b want 00001", {awvalid, wvalid, arvalid, rsp_valid, req_ready}); end
    run_txn(1, 32'h6004, 32'h77, 4'hF, 1, 1, 2, -1, -1, 2'b00, 32'h0, 0);
    checks++; if ({rsp_k == 3, got_error, got_awaddr} !== {2'b10, 32'h6004}) begin errors++; $display("FAIL post_reset_wr k=%0d err=%b awaddr=%h want 3/0/6004", rsp_k, got_error, got_awaddr); end
  endtask

  task automatic test_slow_consumer();
    run_txn(0, 32'h7000, 32'h0, 4'h0, -1, -1, -1, 1, 2, 2'b00, 32'h13572468, 500);
    checks++; if (ack_k !== rsp_k + 500 || rsp_k !== 3) begin errors++; $display("FAIL hold_ack rsp_k=%0d ack_k=%0d want 3/503", rsp_k, ack_k); end
    checks++; if ({stable_ok, got_timeout, got_error, got_data} !== {3'b100, 32'h13572468}) begin errors++; $display("FAIL hold_rsp stable=%b to=%b err=%b data=%h want 1/0/0/13572468", stable_ok, got_timeout, got_error, got_data); end
  endtask

  task automatic test_back_to_back();
    run_txn(1, 32'h8000, 32'h1, 4'hF, 1, 1, 2, -1, -1, 2'b00, 32'h0, 0);
    run_txn(0, 32'h8004, 32'h0, 4'h0, -1, -1, -1, 1, 2, 2'b00, 32'h2468ACE0, 0);
    checks++; if ({rsp_k == 3, got_data} !== {1'b1, 32'h2468ACE0}) begin errors++; $display("FAIL b2b_rd k=%0d data=%h want 3/2468ace0", rsp_k, got_data); end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_write_order();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_slow_consumer();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
